// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin channel mux.
// Holds the parameter limits and the select-width derivation.
package mux_pkg;

    localparam int N_MIN     = 2;
    localparam int N_MAX     = 16;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr or fixed priority.
// Produces a one-hot grant plus its binary index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int RR_EN = 1,
    parameter int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic             found;
    logic [SEL_W-1:0] base;

    // Two-pass search: channels at or above base first, then the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        base      = (RR_EN != 0) ? ptr : '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (SEL_W'(i) >= base)) begin
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel arbitrated mux with a single registered output stage.
// One word per cycle under full flow; holds steady under backpressure.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    parameter  int RR_EN = 1,
    localparam int SEL_W = sel_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_sel
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("rr_mux_n: N out of range");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("rr_mux_n: WIDTH out of range");
    end

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] sel_word;
    logic             load;
    logic             xfer;

    rr_arbiter #(
        .N     (N),
        .RR_EN (RR_EN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Output stage may take a word when empty or being drained.
    assign load     = ~out_valid | out_ready;
    // rst_n gating keeps in_ready low for the whole reset window.
    assign in_ready = grant & {N{load & rst_n}};
    assign xfer     = |in_ready;

    // One-hot AND-OR select of the granted channel's word.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            sel_word = sel_word
                     | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // Output register: load on transfer, clear valid when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_word;
                out_sel  <= grant_idx;
            end
        end
    end

    if (RR_EN != 0) begin : g_rr
        // Priority pointer moves just past the last served channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr <= '0;
            end else if (xfer) begin
                if (grant_idx == SEL_W'(N - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + SEL_W'(1);
                end
            end
        end
    end else begin : g_fixed
        assign ptr = '0;
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n (N=4, WIDTH=16).
// Vector table, hand sequences, and a randomized scoreboard run.
module tb_rr_mux_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0]  in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  out_sel;

    logic [3:0]  fp_in_ready;
    logic [15:0] fp_out_data;
    logic        fp_out_valid;
    logic [1:0]  fp_out_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_mux_n #(.N(4), .WIDTH(16), .RR_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    rr_mux_n #(.N(4), .WIDTH(16), .RR_EN(0)) dut_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (fp_in_ready),
        .out_data  (fp_out_data),
        .out_valid (fp_out_valid),
        .out_ready (out_ready),
        .out_sel   (fp_out_sel)
    );

    typedef struct {
        logic [3:0]  vin;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  os;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] data;
    } exp_t;

    vec_t tbl[17];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        // in_data = {87, 32, 16, 4}
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'd4,  2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'd16, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'd32, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'd87, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'd4,  2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'd16, 2'd1};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'd16, 2'd1};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'd16, 2'd1};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 16'd16, 2'd1};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'd32, 2'd2};
        tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 16'd16, 2'd1};
        tbl[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 16'd87, 2'd3};
        tbl[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 16'd32, 2'd2};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd32, 2'd2};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd32, 2'd2};
        tbl[15] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'd87, 2'd3};
        tbl[16] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'd4,  2'd0};

        rst_n     = 1'b0;
        in_data   = {16'd87, 16'd32, 16'd16, 16'd4};
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_sel",   64'(out_sel),   64'd0);
        chk("rst_ready", 64'(in_ready),  64'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 17; r++) begin
            in_valid  = tbl[r].vin;
            out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", r), 64'(in_ready),
                64'(tbl[r].rdy));
            step();
            chk($sformatf("tbl%0d_valid", r), 64'(out_valid),
                64'(tbl[r].ov));
            chk($sformatf("tbl%0d_data", r), 64'(out_data),
                64'(tbl[r].od));
            chk($sformatf("tbl%0d_sel", r), 64'(out_sel),
                64'(tbl[r].os));
        end

        // Mid-stream reset: outputs clear without waiting for an edge.
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_sel",   64'(out_sel),   64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd0);
        step();
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'b0001);
        step();
        chk("post_rst_sel",  64'(out_sel),  64'd0);
        chk("post_rst_data", 64'(out_data), 64'd4);

        // Fixed-priority instance: channel 0 always wins.
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("fp%0d_in_ready", c), 64'(fp_in_ready),
                64'b0001);
            step();
            chk($sformatf("fp%0d_sel", c), 64'(fp_out_sel), 64'd0);
            chk($sformatf("fp%0d_data", c), 64'(fp_out_data), 64'd4);
        end
        in_valid = 4'b1010;
        #1;
        chk("fp_sparse_ready", 64'(fp_in_ready), 64'b0010);

        // Randomized run against a reference model and scoreboard.
        rst_n = 1'b0;
        #1;
        rst_n    = 1'b1;
        in_valid = '0;
        begin
            int   ptr_m;
            logic ov_m;
            logic ld;
            int   ch;
            exp_t e;
            ptr_m = 0;
            ov_m  = 1'b0;
            for (int c = 0; c < 300; c++) begin
                in_data   = {$urandom(), $urandom()};
                in_valid  = 4'($urandom_range(0, 15));
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                ld = !ov_m || out_ready;
                ch = ld ? pick(in_valid, ptr_m) : -1;
                if (ch >= 0) begin
                    e.sel  = 2'(ch);
                    e.data = in_data[ch*16 +: 16];
                    sb.push_back(e);
                    ptr_m = (ch + 1) % 4;
                end
                chk("sb_in_ready", 64'(in_ready),
                    (ch >= 0) ? (64'd1 << ch) : 64'd0);
                step();
                if (ld) ov_m = (ch >= 0);
                chk("sb_valid", 64'(out_valid), 64'(ov_m));
                if (ch >= 0) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty got=word want=none");
                    end else begin
                        e = sb.pop_front();
                        chk("sb_sel",  64'(out_sel),  64'(e.sel));
                        chk("sb_data", 64'(out_data), 64'(e.data));
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
